// File: rtl/rf_c_writeback.sv
// 16-entry register file with write-through bypass and a per-register pending-write scoreboard.
// Reads and Stall are combinational; writes, busy bits and Pend_cnt update on the next edge; stalled issues leave state untouched.
module rf_c_writeback #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Issue_en,
    input  logic [3:0]        Issue_C,
    input  logic              Use_A,
    input  logic              Use_B,
    input  logic [3:0]        RA,
    input  logic [3:0]        RB,
    input  logic              WB_en,
    input  logic [3:0]        WB_C,
    input  logic [DATA_W-1:0] WB_data,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic              Stall,
    output logic [NREG-1:0]   Busy_vec,
    output logic [4:0]        Pend_cnt
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] rf_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [4:0]        pend_q, pend_d;

    logic [NREG-1:0]   wb_dec;
    logic [NREG-1:0]   issue_dec;
    logic [NREG-1:0]   ebusy;
    logic              stall_c;

    always_comb begin
        wb_dec = WB_en ? (ONE << WB_C) : '0;
        // A writeback landing this cycle clears its own hazard immediately.
        ebusy  = busy_q & ~wb_dec;
        stall_c = Issue_en & ((Use_A & ebusy[RA]) |
                              (Use_B & ebusy[RB]) |
                              ebusy[Issue_C]);
        issue_dec = (Issue_en & ~stall_c) ? (ONE << Issue_C) : '0;
        // Set after clear: a new producer wins over a same-cycle writeback.
        busy_d = (busy_q & ~wb_dec) | issue_dec;
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_d = pend_d + 5'(busy_d[i]);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_dec[i]) begin
                    rf_q[i] <= WB_data;
                end
            end
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign PA       = wb_dec[RA] ? WB_data : rf_q[RA];
    assign PB       = wb_dec[RB] ? WB_data : rf_q[RB];
    assign Stall    = stall_c;
    assign Busy_vec = busy_q;
    assign Pend_cnt = pend_q;

endmodule

// File: tb/tb_rf_c_writeback.sv
module tb_rf_c_writeback;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        Issue_en;
    logic [3:0]  Issue_C;
    logic        Use_A;
    logic        Use_B;
    logic [3:0]  RA;
    logic [3:0]  RB;
    logic        WB_en;
    logic [3:0]  WB_C;
    logic [31:0] WB_data;
    logic [31:0] PA;
    logic [31:0] PB;
    logic        Stall;
    logic [15:0] Busy_vec;
    logic [4:0]  Pend_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    rf_c_writeback #(.DATA_W(32), .NREG(16)) dut (
        .Clk(Clk), .Clr(Clr), .Issue_en(Issue_en), .Issue_C(Issue_C),
        .Use_A(Use_A), .Use_B(Use_B), .RA(RA), .RB(RB),
        .WB_en(WB_en), .WB_C(WB_C), .WB_data(WB_data),
        .PA(PA), .PB(PB), .Stall(Stall), .Busy_vec(Busy_vec), .Pend_cnt(Pend_cnt)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain register array plus a set of pending destinations.
    logic [31:0] m_rf [16];
    bit          m_busy [16];

    function automatic bit m_ebusy(input logic [3:0] r);
        return m_busy[r] && !(WB_en && WB_C == r);
    endfunction

    function automatic bit m_stall();
        return Issue_en && ((Use_A && m_ebusy(RA)) || (Use_B && m_ebusy(RB)) || m_ebusy(Issue_C));
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] r);
        return (WB_en && WB_C == r) ? WB_data : m_rf[r];
    endfunction

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [4:0] m_pend();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
        return 5'(n);
    endfunction

    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < 16; i++) begin
                m_rf[i]   = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            bit accept;
            accept = Issue_en && !m_stall();
            if (WB_en) begin
                m_rf[WB_C]   = WB_data;
                m_busy[WB_C] = 1'b0;
            end
            if (accept) m_busy[Issue_C] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_on) begin
            check("cyc_PA", PA, m_read(RA));
            check("cyc_PB", PB, m_read(RB));
            check("cyc_Stall", 32'(Stall), 32'(m_stall()));
            check("cyc_Busy", 32'(Busy_vec), 32'(m_busy_vec()));
            check("cyc_Pend", 32'(Pend_cnt), 32'(m_pend()));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Issue_en = 0; Use_A = 0; Use_B = 0; WB_en = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        Clr = 1; Issue_en = 0; Issue_C = 0; Use_A = 0; Use_B = 0;
        RA = 0; RB = 0; WB_en = 0; WB_C = 0; WB_data = 0;
        #1;
        cmp_on = 1'b1;
        step(); step();
        check("rst_Busy", 32'(Busy_vec), 32'h0);
        check("rst_Pend", 32'(Pend_cnt), 32'h0);
        check("rst_Stall", 32'(Stall), 32'h0);
        check("rst_PA", PA, 32'h0);
        Clr = 0;
        step();

        // Async reset wipes a written register without a clock edge
        WB_en = 1; WB_C = 3; WB_data = 32'hDEADBEEF;
        step();
        WB_en = 0; RA = 3;
        #2 check("pre_clr_PA", PA, 32'hDEADBEEF);
        #1 Clr = 1;
        #1 check("clr_PA", PA, 32'h0);
        check("clr_Busy", 32'(Busy_vec), 32'h0);
        check("clr_Pend", 32'(Pend_cnt), 32'h0);
        #2 Clr = 0;
        step();

        // Basic write then read
        WB_en = 1; WB_C = 5; WB_data = 32'h12345678;
        step();
        WB_en = 0; RA = 5; RB = 4;
        #2 check("wr_PA", PA, 32'h12345678);
        check("wr_PB", PB, 32'h0);

        // Same-cycle bypass
        step();
        WB_en = 1; WB_C = 7; WB_data = 32'hA5A5A5A5; RA = 7;
        #2 check("byp_PA", PA, 32'hA5A5A5A5);
        step();
        idle();

        // RAW stall, released by a same-cycle writeback
        Issue_en = 1; Issue_C = 2;
        #2 check("raw_issue_Stall", 32'(Stall), 32'h0);
        step();
        Issue_C = 3; Use_A = 1; RA = 2;
        #2 check("raw_Busy", 32'(Busy_vec), 32'h0004);
        check("raw_Pend", 32'(Pend_cnt), 32'h1);
        check("raw_Stall", 32'(Stall), 32'h1);
        WB_en = 1; WB_C = 2; WB_data = 32'h0000_0022;
        #1 check("raw_wb_Stall", 32'(Stall), 32'h0);
        step();
        idle();
        #2 check("raw_after_Busy", 32'(Busy_vec), 32'h0008);
        check("raw_after_Pend", 32'(Pend_cnt), 32'h1);

        // WAW and simultaneous set/clear on R9
        Issue_en = 1; Issue_C = 9;
        step();
        idle();
        #2 check("waw_Busy", 32'(Busy_vec), 32'h0208);
        Issue_en = 1; Issue_C = 9;
        #1 check("waw_Stall", 32'(Stall), 32'h1);
        WB_en = 1; WB_C = 9; WB_data = 32'h99990000;
        #1 check("waw_wb_Stall", 32'(Stall), 32'h0);
        step();
        idle(); RA = 9;
        #2 check("setclr_Busy", 32'(Busy_vec), 32'h0208);
        check("setclr_Pend", 32'(Pend_cnt), 32'h2);
        check("setclr_PA", PA, 32'h99990000);

        // Drain
        WB_en = 1; WB_C = 3; WB_data = 32'h3;
        step();
        WB_C = 9; WB_data = 32'h9;
        step();
        idle();
        #2 check("drain_Pend", 32'(Pend_cnt), 32'h0);

        // Occupancy: fill all 16
        for (int i = 0; i < 16; i++) begin
            Issue_en = 1; Issue_C = 4'(i);
            step();
            #2 check("fill_Pend", 32'(Pend_cnt), 32'(i + 1));
        end
        idle();
        #1 check("full_Busy", 32'(Busy_vec), 32'hFFFF);
        check("full_Pend", 32'(Pend_cnt), 32'd16);
        Issue_en = 1; Issue_C = 4'd0; Use_B = 1; RB = 4'd6;
        #1 check("full_Stall", 32'(Stall), 32'h1);
        step();
        idle();
        #1 check("full_hold_Pend", 32'(Pend_cnt), 32'd16);

        // Release all, then a writeback to a non-busy register
        for (int i = 0; i < 16; i++) begin
            WB_en = 1; WB_C = 4'(i); WB_data = 32'(i) * 32'h01010101;
            step();
        end
        idle();
        #1 check("empty_Pend", 32'(Pend_cnt), 32'h0);
        WB_en = 1; WB_C = 4'd15; WB_data = 32'hCAFEF00D;
        step();
        idle(); RA = 15; RB = 4;
        #1 check("nb_Pend", 32'(Pend_cnt), 32'h0);
        check("nb_Busy", 32'(Busy_vec), 32'h0);
        check("nb_PA", PA, 32'hCAFEF00D);
        check("nb_PB", PB, 32'h04040404);
        step(); step();

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_c_writeback.md
Name: rf_c_writeback

Overview:
- Destination-side consumer of the 4-bit C register address produced by the C-select path (IR[15:12], all-ones/R15, IR[19:16], external).
- Decodes C into a 16-entry register-file write port with two read ports, A and B.
- Keeps a per-register pending-write scoreboard: C is registered as busy at issue and released at writeback.
- Stalls issue on RAW and WAW hazards; sits between the decode stage and the writeback stage.

Parameters:
DATA_W, 32, register and data width in bits
NREG, 16, number of registers; fixed by the 4-bit address, not to be changed

Ports:
Clk  input  1  system clock, rising-edge
Clr  input  1  reset, asynchronous, active-high
Issue_en  input  1  decode stage presents an instruction this cycle
Issue_C  input  4  destination register address from the C-select path
Use_A  input  1  issuing instruction reads port A
Use_B  input  1  issuing instruction reads port B
RA  input  4  read address, port A
RB  input  4  read address, port B
WB_en  input  1  writeback valid this cycle
WB_C  input  4  writeback destination address
WB_data  input  DATA_W  writeback data
PA  output  DATA_W  read data, port A
PB  output  DATA_W  read data, port B
Stall  output  1  issue must be held; decode repeats the instruction next cycle
Busy_vec  output  16  pending-write bit per register
Pend_cnt  output  5  number of set bits in Busy_vec, 0..16

Behaviour:
- Clr asserted, asynchronous: R0..R15 = 0, Busy_vec = 0, Pend_cnt = 0. PA/PB then read 0 and Stall is 0. Clr overrides any in-flight issue or writeback in that cycle.
- Write decode: WB_C is decoded one-hot 4-to-16. On rising Clk with WB_en = 1, R[WB_C] <= WB_data. Exactly one register is written, with one cycle of latency.
- Write-through bypass, combinational:
  - PA = WB_data when WB_en and WB_C == RA; otherwise PA = R[RA].
  - PB follows the same rule with RB.
- Effective busy: ebusy[i] = Busy_vec[i] AND NOT (WB_en AND WB_C == i). A writeback in the current cycle resolves its hazard in that same cycle.
- Stall (combinational) = Issue_en AND any of:
  - Use_A and ebusy[RA];
  - Use_B and ebusy[RB];
  - ebusy[Issue_C] (WAW).
- Issue accepted = Issue_en AND NOT Stall. On rising Clk, Busy_vec[Issue_C] <= 1.
- Writeback on rising Clk: Busy_vec[WB_C] <= 0.
- Simultaneous accepted issue and writeback to the same register: the set wins, so the bit ends at 1 (new producer). The data write still occurs.
- Writeback to a register that is not busy: data is written and the busy bit stays 0. This is legal and raises no error.
- Stalled issue: Busy_vec is unchanged. The decode stage holds its inputs.
- Pend_cnt is registered and equals the popcount of the next-state Busy_vec, updated on the same edge. With one set and one clear per cycle, it changes by at most ±1 per cycle.
- R15 has no special treatment here; PC logic is outside this block. C = 4'b1111 is handled like any other address.
- Combinational read paths have no state machine. The scoreboard is 16 independent set/clear flops with a priority of Clr > set > clear.

Test Plan:
- Reset: write R3 = 0xDEADBEEF, then pulse Clr mid-cycle without a clock edge -> PA (RA=3) = 0 immediately; Busy_vec = 0, Pend_cnt = 0.
- Basic write/read: WB_en=1, WB_C=5, WB_data=0x12345678 for one edge, then RA=5 -> PA = 0x12345678; PB (RB=4) = 0.
- Bypass: WB_en=1, WB_C=7, WB_data=0xA5A5A5A5, RA=7, before the edge -> PA = 0xA5A5A5A5 in the same cycle.
- RAW stall: issue C=2 (accepted, Busy_vec[2]=1, Pend_cnt=1); next cycle Issue_en=1, Use_A=1, RA=2 -> Stall=1. Then WB_en=1, WB_C=2 in the same cycle -> Stall=0 and the issue is accepted.
- WAW and simultaneous set/clear: Busy_vec[9]=1. Issue C=9 with no writeback -> Stall=1. Issue C=9 with WB_C=9, WB_en=1 -> Stall=0; after the edge, Busy_vec[9]=1, R9 = WB_data, Pend_cnt unchanged.
- Occupancy: issue C = 0..15 on consecutive cycles with no writeback -> Pend_cnt climbs to 16, Busy_vec = 0xFFFF. Any further issue -> Stall=1. Then writeback R15 to a non-busy register after clears -> Pend_cnt does not go below 0.
